// File: rtl/icsp_programmer_pkg.sv
// Shared definitions for the ICSP programmer: command codes, FSM state
// encodings, erase value and the wrapping address-step helper.
`timescale 1ns/1ps
package icsp_programmer_pkg;

  // 6-bit serial command codes, shifted in LSB-first
  localparam logic [5:0] CMD_LOAD_DATA  = 6'h02;
  localparam logic [5:0] CMD_READ_DATA  = 6'h04;
  localparam logic [5:0] CMD_INC_ADDR   = 6'h06;
  localparam logic [5:0] CMD_BEGIN_PROG = 6'h08;
  localparam logic [5:0] CMD_BULK_ERASE = 6'h09;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD      = 3'd1;
  localparam logic [2:0] ST_DATA_IN  = 3'd2;
  localparam logic [2:0] ST_RD_FETCH = 3'd3;
  localparam logic [2:0] ST_DATA_OUT = 3'd4;
  localparam logic [2:0] ST_PROG     = 3'd5;
  localparam logic [2:0] ST_ERASE    = 3'd6;

  // Blank flash word
  localparam logic [13:0] ERASE_VALUE = 14'h3FFF;

  // Next address, wrapping from last back to 0
  function automatic logic [11:0] addr_next(input logic [11:0] a,
                                            input logic [11:0] last);
    return (a == last) ? 12'd0 : a + 12'd1;
  endfunction

endpackage

// File: rtl/icsp_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall
// pulses. A pin transition shows up as a one-clk pulse 3 clk later.
// With EDGE_EN=0 only the synchronized level is meaningful.
`timescale 1ns/1ps
module icsp_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  assign sync = s2;

  // Synchronizer chain, delayed copy, and registered edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= EDGE_EN & s2 & ~s3;
      fall <= EDGE_EN & ~s2 & s3;
    end
  end

endmodule

// File: rtl/icsp_programmer.sv
// ICSP serial programming controller. Commands and data arrive LSB-first on
// falling icsp_clk edges; read data is driven on rising edges. Drives the
// program-memory write port for single-word programming and bulk erase.
`timescale 1ns/1ps
module icsp_programmer
  import icsp_programmer_pkg::*;
#(
  parameter int MEM_DEPTH   = 1024,
  parameter int PROG_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_mode,
  input  logic        icsp_clk,
  input  logic        icsp_data_in,
  output logic        icsp_data_out,
  output logic        icsp_data_oe,
  output logic [11:0] mem_addr,
  output logic [13:0] mem_wdata,
  output logic        mem_we,
  input  logic [13:0] mem_rdata,
  output logic        busy,
  output logic        cpu_hold
);

  localparam logic [11:0] ADDR_LAST = 12'(MEM_DEPTH - 1);
  localparam logic [15:0] PROG_LAST = 16'(PROG_CYCLES - 1);

  logic        clk_rise, clk_fall, din_sync;
  logic        unused_clk_lvl, unused_din_rise, unused_din_fall;
  logic [2:0]  state;
  logic [11:0] addr, saved_addr;
  logic [13:0] data_latch;
  logic [15:0] shreg, cnt;
  logic [4:0]  bitcnt;
  logic        pm_q;
  logic [15:0] sh_next;
  logic [5:0]  cmd_next;

  icsp_sync_edge #(.EDGE_EN(1'b1)) u_clk_sync (
    .clk  (clk),
    .reset(reset),
    .din  (icsp_clk),
    .sync (unused_clk_lvl),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  icsp_sync_edge #(.EDGE_EN(1'b0)) u_data_sync (
    .clk  (clk),
    .reset(reset),
    .din  (icsp_data_in),
    .sync (din_sync),
    .rise (unused_din_rise),
    .fall (unused_din_fall)
  );

  // LSB-first shift: new bit enters at the top; after 6 shifts the command
  // sits in [15:10], after 16 shifts the full frame sits in [15:0].
  assign sh_next   = {din_sync, shreg[15:1]};
  assign cmd_next  = sh_next[15:10];
  assign mem_addr  = addr;
  assign mem_wdata = (state == ST_ERASE) ? ERASE_VALUE : data_latch;
  assign cpu_hold  = prog_mode;

  // Main protocol FSM, address counter and memory-write sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      saved_addr    <= '0;
      data_latch    <= ERASE_VALUE;
      shreg         <= '0;
      bitcnt        <= '0;
      cnt           <= '0;
      pm_q          <= 1'b0;
      mem_we        <= 1'b0;
      busy          <= 1'b0;
      icsp_data_oe  <= 1'b0;
      icsp_data_out <= 1'b0;
    end else begin
      pm_q   <= prog_mode;
      mem_we <= 1'b0;
      if (!prog_mode) begin
        // Leaving programming mode aborts whatever is in flight
        state         <= ST_IDLE;
        busy          <= 1'b0;
        icsp_data_oe  <= 1'b0;
        icsp_data_out <= 1'b0;
        bitcnt        <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state  <= ST_CMD;
            bitcnt <= '0;
            shreg  <= '0;
          end
          ST_CMD: if (clk_fall) begin
            if (bitcnt == 5'd5) begin
              bitcnt <= '0;
              shreg  <= '0;
              case (cmd_next)
                CMD_LOAD_DATA:  state <= ST_DATA_IN;
                CMD_READ_DATA: begin
                  state <= ST_RD_FETCH;
                  cnt   <= '0;
                end
                CMD_INC_ADDR:   addr <= addr_next(addr, ADDR_LAST);
                CMD_BEGIN_PROG: begin
                  mem_we <= 1'b1;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  state  <= ST_PROG;
                end
                CMD_BULK_ERASE: begin
                  saved_addr <= addr;
                  addr       <= '0;
                  mem_we     <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_ERASE;
                end
                default: ;
              endcase
            end else begin
              bitcnt <= bitcnt + 5'd1;
              shreg  <= sh_next;
            end
          end
          ST_DATA_IN: if (clk_fall) begin
            if (bitcnt == 5'd15) begin
              // Frame is start, data[13:0], stop; framing bits are dropped
              data_latch <= sh_next[14:1];
              bitcnt     <= '0;
              shreg      <= '0;
              state      <= ST_CMD;
            end else begin
              bitcnt <= bitcnt + 5'd1;
              shreg  <= sh_next;
            end
          end
          ST_RD_FETCH: begin
            // Give the registered memory read time to settle at addr
            if (cnt == 16'd2) begin
              shreg        <= {1'b0, mem_rdata, 1'b0};
              bitcnt       <= '0;
              icsp_data_oe <= 1'b1;
              state        <= ST_DATA_OUT;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_DATA_OUT: begin
            if (clk_rise) begin
              icsp_data_out <= shreg[0];
              shreg         <= {1'b0, shreg[15:1]};
            end
            if (clk_fall) begin
              if (bitcnt == 5'd15) begin
                icsp_data_oe  <= 1'b0;
                icsp_data_out <= 1'b0;
                bitcnt        <= '0;
                state         <= ST_CMD;
              end else begin
                bitcnt <= bitcnt + 5'd1;
              end
            end
          end
          ST_PROG: begin
            if (cnt == PROG_LAST) begin
              busy  <= 1'b0;
              state <= ST_CMD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_ERASE: begin
            // Walk the whole array, then restore the caller's address
            if (addr == ADDR_LAST) begin
              addr  <= saved_addr;
              busy  <= 1'b0;
              state <= ST_CMD;
            end else begin
              addr   <= addr + 12'd1;
              mem_we <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      // Each entry into programming mode starts from address 0
      if (prog_mode && !pm_q) addr <= '0;
    end
  end

endmodule

// File: tb/tb_icsp_programmer.sv
// Directed bench for icsp_programmer: reset, load/program, read-back,
// address wrap, bulk erase, erase abort and illegal/ignored input.
`timescale 1ns/1ps
module tb_icsp_programmer;
  import icsp_programmer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, prog_mode, icsp_clk, icsp_data_in;
  logic        icsp_data_out, icsp_data_oe, mem_we, busy, cpu_hold;
  logic [11:0] mem_addr;
  logic [13:0] mem_wdata, mem_rdata;
  logic [13:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  int          cyc = 0, we_count = 0, seq_bad = 0, busy_cnt = 0;
  int          first_we = 0, last_we = 0;
  logic [11:0] exp_addr = '0, last_waddr = '0;
  logic [13:0] last_wdata = '0;
  bit          erase_track = 1'b0;

  icsp_programmer dut (
    .clk          (clk),
    .reset        (reset),
    .prog_mode    (prog_mode),
    .icsp_clk     (icsp_clk),
    .icsp_data_in (icsp_data_in),
    .icsp_data_out(icsp_data_out),
    .icsp_data_oe (icsp_data_oe),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .cpu_hold     (cpu_hold)
  );

  always #5 clk = ~clk;

  // Program memory model: write port plus registered read
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  // Write/busy monitor sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (busy === 1'b1) busy_cnt++;
    if (mem_we === 1'b1) begin
      we_count++;
      if (we_count == 1) first_we = cyc;
      last_we    = cyc;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
      if (erase_track) begin
        if (mem_addr !== exp_addr || mem_wdata !== ERASE_VALUE) seq_bad++;
        exp_addr = exp_addr + 12'd1;
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    icsp_data_in = b;
    icsp_clk = 1'b1;
    tick(5);
    icsp_clk = 1'b0;
    tick(5);
  endtask

  task automatic send_cmd(input logic [5:0] c);
    for (int i = 0; i < 6; i++) send_bit(c[i]);
  endtask

  task automatic send_word(input logic [13:0] d);
    logic [15:0] w;
    w = {1'b0, d, 1'b0};
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  task automatic recv_word(output logic [15:0] w, output int oe_hi);
    w = '0;
    oe_hi = 0;
    for (int i = 0; i < 16; i++) begin
      icsp_clk = 1'b1;
      tick(5);
      w[i] = icsp_data_out;
      if (icsp_data_oe === 1'b1) oe_hi++;
      icsp_clk = 1'b0;
      tick(5);
    end
  endtask

  task automatic wait_busy_low(input int maxc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      tick(1);
      n++;
    end
    check("busy_wait_bound", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] rw;
    int          oe_hi, wc, n;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset = 1'b1; prog_mode = 1'b0; icsp_clk = 1'b0; icsp_data_in = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_oe",       {31'd0, icsp_data_oe}, 32'd0);
    check("rst_dout",     {31'd0, icsp_data_out}, 32'd0);
    check("rst_addr",     {20'd0, mem_addr}, 32'd0);
    check("rst_state",    {29'd0, dut.state}, {29'd0, ST_IDLE});
    check("rst_latch",    {18'd0, dut.data_latch}, 32'h3FFF);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // Load and program
    prog_mode = 1'b1;
    tick(3);
    check("hold_on", {31'd0, cpu_hold}, 32'd1);
    send_cmd(CMD_LOAD_DATA);
    send_word(14'h1A5C);
    we_count = 0; busy_cnt = 0;
    send_cmd(CMD_BEGIN_PROG);
    wait_busy_low(100);
    check("prog_we_count", we_count, 32'd1);
    check("prog_addr",     {20'd0, last_waddr}, 32'd0);
    check("prog_wdata",    {18'd0, last_wdata}, 32'h1A5C);
    check("prog_busy_len", busy_cnt, 32'd16);

    // Read back from address 3
    prog_mode = 1'b0;
    tick(2);
    check("pm_off_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
    prog_mode = 1'b1;
    tick(2);
    check("pm_on_addr0", {20'd0, mem_addr}, 32'd0);
    mem[3] = 14'h2F01;
    repeat (3) send_cmd(CMD_INC_ADDR);
    check("inc3_addr", {20'd0, mem_addr}, 32'd3);
    send_cmd(CMD_READ_DATA);
    tick(4);
    recv_word(rw, oe_hi);
    check("read_bits",  {16'd0, rw}, 32'h5E02);
    check("read_oe_hi", oe_hi, 32'd16);
    tick(2);
    check("read_oe_off", {31'd0, icsp_data_oe}, 32'd0);

    // Address wrap
    prog_mode = 1'b0; tick(2); prog_mode = 1'b1; tick(2);
    repeat (1023) send_cmd(CMD_INC_ADDR);
    check("wrap_1023", {20'd0, mem_addr}, 32'h3FF);
    send_cmd(CMD_INC_ADDR);
    check("wrap_1024", {20'd0, mem_addr}, 32'd0);

    // Bulk erase from address 5
    repeat (5) send_cmd(CMD_INC_ADDR);
    check("pre_erase_addr", {20'd0, mem_addr}, 32'd5);
    we_count = 0; seq_bad = 0; exp_addr = '0; erase_track = 1'b1;
    send_cmd(CMD_BULK_ERASE);
    wait_busy_low(2000);
    tick(2);
    erase_track = 1'b0;
    check("erase_we_count", we_count, 32'd1024);
    check("erase_seq",      seq_bad, 32'd0);
    check("erase_contig",   last_we - first_we, 32'd1023);
    check("erase_restore",  {20'd0, mem_addr}, 32'd5);
    check("erase_busy",     {31'd0, busy}, 32'd0);

    // Abort erase at address 100
    send_cmd(CMD_BULK_ERASE);
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == 12'd100) && n < 2000) begin
      tick(1);
      n++;
    end
    check("abort_reach100", {20'd0, mem_addr}, 32'd100);
    prog_mode = 1'b0;
    tick(1);
    check("abort_we",    {31'd0, mem_we}, 32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
    check("abort_hold",  {31'd0, cpu_hold}, 32'd0);
    check("abort_oe",    {31'd0, icsp_data_oe}, 32'd0);
    wc = we_count;
    tick(20);
    check("abort_no_more_we", we_count, wc);

    // Illegal command, then a normal load; edges during PROG ignored
    prog_mode = 1'b1;
    tick(3);
    we_count = 0;
    send_cmd(6'h3F);
    send_cmd(CMD_LOAD_DATA);
    send_word(14'h0001);
    tick(2);
    check("illegal_no_we", we_count, 32'd0);
    check("illegal_latch", {18'd0, dut.data_latch}, 32'h0001);
    send_cmd(CMD_BEGIN_PROG);
    send_bit(1'b1);
    wait_busy_low(100);
    check("prog2_we_count", we_count, 32'd1);
    check("prog2_wdata",    {18'd0, last_wdata}, 32'h0001);
    check("prog2_addr",     {20'd0, last_waddr}, 32'd0);
    send_cmd(CMD_READ_DATA);
    tick(4);
    recv_word(rw, oe_hi);
    check("read2_bits",  {16'd0, rw}, 32'h0002);
    check("read2_oe_hi", oe_hi, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
